riscboy_ppu_pxexpand: RTL

Palette-expansion stage directly upstream of the PPU pixel FIFO, in the PPU clock domain. Accepts 32-bit words of packed indexed pixels and looks each index up in a 256-entry RGB565 palette RAM. Pushes one 16-bit pixel per cycle into the async pixel FIFO write port, with full valid/ready backpressure. The palette is written from the PPU register block.

---
 rtl/riscboy_ppu_pxexpand.sv | 113 +++++++++++
 1 files changed

// File: rtl/riscboy_ppu_pxexpand.sv
// riscboy_ppu_pxexpand: unpacks indexed pixels, looks them up in a 256x16 palette and feeds the pixel FIFO; macro RISCBOY_PPU_PXEXPAND_DIRECT_EN adds 16bpp direct mode
module riscboy_ppu_pxexpand #(
  parameter int W_PXDATA = 16,
  parameter int W_SRC = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_vld,
  output logic                src_rdy,
  input  logic [W_SRC-1:0]    src_data,
  input  logic [2:0]          src_bpp,
  input  logic [7:0]          src_pal_base,
  input  logic                pal_wen,
  input  logic [7:0]          pal_waddr,
  input  logic [W_PXDATA-1:0] pal_wdata,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [W_PXDATA-1:0] out_data,
  output logic                busy
);
  logic                u_vld;
  logic [W_SRC-1:0]    u_word;
  logic [2:0]          u_bpp;
  logic [7:0]          u_base;
  logic [4:0]          k;
  logic                rd_vld;
  logic [W_PXDATA-1:0] ram_q;
  logic [W_PXDATA-1:0] rd_data;
  logic [W_PXDATA-1:0] pal_mem [256];
  logic [W_PXDATA-1:0] b [2];
  logic [1:0]          cnt;
  logic [4:0]          sh;
  logic [7:0]          mask;
  logic [7:0]          idx;
  logic [7:0]          addr;
  logic [2:0]          bpp_in;
  logic                last;
  logic                pop;
  logic                pop_buf;
  logic                push;
  logic                issue;
  logic                widx;
`ifdef RISCBOY_PPU_PXEXPAND_DIRECT_EN
  logic                rd_dir;
  logic [W_PXDATA-1:0] rd_dir_data;
`endif
  // Pixel extraction, issue slot accounting and output selection; the in-flight read bypasses an empty buffer
  always_comb begin
`ifdef RISCBOY_PPU_PXEXPAND_DIRECT_EN
    bpp_in = src_bpp == 3'd4 ? 3'd4 : src_bpp > 3'd3 ? 3'd3 : src_bpp;
    rd_data = rd_dir ? rd_dir_data : ram_q;
`else
    bpp_in = src_bpp > 3'd3 ? 3'd3 : src_bpp;
    rd_data = ram_q;
`endif
    sh = k << u_bpp[1:0];
    mask = 8'((9'd1 << (4'd1 << u_bpp[1:0])) - 9'd1);
    idx = 8'(u_word >> sh) & mask;
    addr = u_base + idx;
    last = k == 5'((6'd32 >> u_bpp) - 6'd1);
    out_vld = cnt != 2'd0 || rd_vld;
    out_data = cnt != 2'd0 ? b[0] : rd_vld ? rd_data : '0;
    pop = out_vld && out_rdy;
    pop_buf = pop && cnt != 2'd0;
    push = rd_vld && !(cnt == 2'd0 && pop);
    widx = 1'(cnt - 2'(pop_buf));
    issue = u_vld && (({1'b0, cnt} + {2'b0, rd_vld}) < 3'd2 || pop);
    src_rdy = !rst && (!u_vld || (issue && last));
    busy = u_vld || rd_vld || cnt != 2'd0;
  end
  // Palette RAM: synchronous read, read-before-write on collision, never reset
  always_ff @(posedge clk) begin
    if (pal_wen) pal_mem[pal_waddr] <= pal_wdata;
    if (issue) ram_q <= pal_mem[addr];
  end
  // Unpack register, read-in-flight flag and buffer occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      u_vld <= 1'b0;
      rd_vld <= 1'b0;
      cnt <= 2'd0;
      k <= 5'd0;
    end else begin
      rd_vld <= issue;
      cnt <= cnt + 2'(push) - 2'(pop_buf);
      if (src_vld && src_rdy) begin
        u_vld <= 1'b1;
        u_word <= src_data;
        u_bpp <= bpp_in;
        u_base <= src_pal_base;
        k <= 5'd0;
      end else if (issue) begin
        k <= k + 5'd1;
        if (last) u_vld <= 1'b0;
      end
    end
  end
  // Two-entry output buffer: head shifts on pop, arriving pixel lands behind the survivors
  always_ff @(posedge clk) begin
    if (pop_buf) b[0] <= b[1];
    if (push) b[widx] <= rd_data;
  end
`ifdef RISCBOY_PPU_PXEXPAND_DIRECT_EN
  // Direct pixels ride alongside the RAM read so latency is unchanged
  always_ff @(posedge clk) begin
    if (rst) rd_dir <= 1'b0;
    else if (issue) begin
      rd_dir <= u_bpp == 3'd4;
      rd_dir_data <= k[0] ? u_word[2*W_PXDATA-1:W_PXDATA] : u_word[W_PXDATA-1:0];
    end
  end
`endif
endmodule
